mips_cycle_control: RTL

- Multicycle sequencer and PC unit for the MIPS_new core. It owns the machine-cycle state and drives it to the datapath as count_state.
- It receives the fetched instruction word and the ALU zero flag from the datapath. It returns the per-phase control strobes and the program counter.
- Supersedes the free-running cycle counter, so each phase is now decided by the control logic. Supports add (R-type), addi, beq and j.

---
 rtl/mips_cycle_control.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mips_cycle_control.sv
// Multicycle sequencer and PC unit for the MIPS_new core: five phases per instruction
// (FETCH, DECODE, EXECUTE, WB_UPC, DUMMY) supporting add, addi, beq and j.
module mips_cycle_control #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int PC_RESET   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  zero,
    output logic [2:0]            count_state,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  ir_we,
    output logic                  reg_we,
    output logic                  regdst,
    output logic                  alusrc_imm,
    output logic [2:0]            alu_op,
    output logic                  instr_done,
    output logic                  illegal
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_WB_UPC  = 3'd4,
        S_DUMMY   = 3'd5
    } state_t;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [ADDR_WIDTH-1:0] pc_q, pc_plus4_q, pc_d;
    logic                  taken_q, illegal_q;
    logic                  ir_we_q, reg_we_q, regdst_q, alusrc_imm_q, instr_done_q;
    logic [2:0]            alu_op_q;
    logic                  is_add, is_addi, is_beq, is_j, is_legal;
    logic [ADDR_WIDTH-1:0] br_off, j_target;
    logic                  unused_ir;

    always_comb begin
        is_add   = (ir_q[31:26] == OP_RTYPE) && (ir_q[5:0] == FN_ADD);
        is_addi  = (ir_q[31:26] == OP_ADDI);
        is_beq   = (ir_q[31:26] == OP_BEQ);
        is_j     = (ir_q[31:26] == OP_J);
        is_legal = is_add | is_addi | is_beq | is_j;
    end

    // PC arithmetic deliberately truncates to ADDR_WIDTH so targets wrap around the address space.
    assign br_off    = ADDR_WIDTH'({{(DATA_WIDTH-16){ir_q[15]}}, ir_q[15:0], 2'b00});
    assign j_target  = {ir_q[ADDR_WIDTH-3:0], 2'b00};
    assign unused_ir = ^ir_q[25:16];

    always_comb begin
        pc_d = pc_plus4_q;
        if (is_j)
            pc_d = j_target;
        else if (is_beq && taken_q)
            pc_d = pc_plus4_q + br_off;
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:    state_d = enable ? S_FETCH : S_IDLE;
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_WB_UPC;
            S_WB_UPC:  state_d = S_DUMMY;
            S_DUMMY:   state_d = enable ? S_FETCH : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with count_state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= ADDR_WIDTH'(PC_RESET);
            pc_plus4_q   <= '0;
            ir_q         <= '0;
            taken_q      <= 1'b0;
            illegal_q    <= 1'b0;
            ir_we_q      <= 1'b0;
            reg_we_q     <= 1'b0;
            regdst_q     <= 1'b0;
            alusrc_imm_q <= 1'b0;
            alu_op_q     <= ALU_ADD;
            instr_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_we_q      <= (state_d == S_FETCH);
            reg_we_q     <= (state_d == S_WB_UPC) && (is_add || is_addi);
            regdst_q     <= ((state_d == S_EXECUTE) || (state_d == S_WB_UPC)) && is_add;
            alusrc_imm_q <= (state_d == S_EXECUTE) && is_addi;
            alu_op_q     <= ((state_d == S_EXECUTE) && is_beq) ? ALU_SUB : ALU_ADD;
            instr_done_q <= (state_d == S_DUMMY);
            case (state_q)
                S_FETCH: begin
                    ir_q       <= instr;
                    pc_plus4_q <= pc_q + ADDR_WIDTH'(4);
                end
                S_DECODE: begin
                    if (!is_legal)
                        illegal_q <= 1'b1;
                end
                S_EXECUTE: taken_q <= is_beq & zero;
                S_WB_UPC:  pc_q    <= pc_d;
                default: ;
            endcase
        end
    end

    assign count_state = state_q;
    assign pc          = pc_q;
    assign ir_we       = ir_we_q;
    assign reg_we      = reg_we_q;
    assign regdst      = regdst_q;
    assign alusrc_imm  = alusrc_imm_q;
    assign alu_op      = alu_op_q;
    assign instr_done  = instr_done_q;
    assign illegal     = illegal_q;

endmodule
